// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for nibble_serial_adder.
// Optional subtract support is enabled by NIBBLE_SERIAL_ADDER_SUB_EN.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  // Handshake: start is taken at a rising edge only when busy=0. done pulses
  // for one cycle when sum/c_out are valid, and they hold until the next done.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             sub;
  logic             ovf;

  modport master (output start, a, b, c_in, sub, input busy, done, sum, c_out, ovf);
  modport slave  (input start, a, b, c_in, sub, output busy, done, sum, c_out, ovf);
`else
  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built by time-sharing one 4-bit ripple slice, LSB nibble first.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub input and the ovf output.
module rca_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  nibble_serial_adder_if.slave bus,
  output logic [1:0]          dbg_state
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, c_out_q;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_co;
  logic             accept, last;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic             sub_q, ovf_q;
`endif

  assign last = (idx_q == LAST);

  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4];
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    if (sub_q) nib_b = ~nib_b;
`endif
  end

  rca_4bit u_slice (
    .x  (nib_a),
    .y  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  // acc_d is the accumulator with this cycle's nibble merged in, so the final
  // edge can publish the complete result directly into sum.
  always_comb begin
    acc_d                      = acc_q;
    acc_d[{idx_q, 2'b00} +: 4] = nib_s;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN:     if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        acc_q <= '0;
        idx_q <= '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub_q   <= bus.sub;
        carry_q <= bus.sub | bus.c_in;
`else
        carry_q <= bus.c_in;
`endif
      end else if (state_q == RUN) begin
        acc_q   <= acc_d;
        carry_q <= nib_co;
        idx_q   <= idx_q + IW'(1);
        if (last) begin
          sum_q   <= acc_d;
          c_out_q <= nib_co;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
          // Carry into the MSB is recovered from the slice's own MSB sum bit.
          ovf_q   <= (nib_a[3] ^ nib_b[3] ^ nib_s[3]) ^ nib_co;
`endif
        end
      end
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign bus.ovf   = ovf_q;
`endif
  assign dbg_state = state_q;
endmodule
